axis_arbiter: RTL
=================

AXIS_ARBITER -- requirements
Module: axis_arbiter

Interface
REQ-001 SHALL have parameter NUM_SIF, default 2, number of requesting stream slaves (legal 2..8).
REQ-002 SHALL have parameter TDATA_WIDTH, default 32, data width of every stream.
REQ-003 SHALL have localparam ID_WIDTH = $clog2(NUM_SIF), width of the grant index.
REQ-004 SHALL have port clk  input  1  single clock; all logic is on the rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port sif_tvalid  input  NUM_SIF  per-requester valid.
REQ-007 SHALL have port sif_tdata  input  NUM_SIF x TDATA_WIDTH  per-requester data.
REQ-008 SHALL have port sif_tready  output  NUM_SIF  per-requester ready.
REQ-009 SHALL have port mif_tvalid  output  1  shared downstream valid.
REQ-010 SHALL have port mif_tdata  output  TDATA_WIDTH  shared downstream data.
REQ-011 SHALL have port mif_tid  output  ID_WIDTH  index of the requester whose beat is on mif.
REQ-012 SHALL have port mif_tready  input  1  downstream ready.
REQ-013 SHALL have port invalidate  input  1  flush of the held output beat.

Function
REQ-014 SHALL register the output: exactly one cycle of latency from sif handshake to mif_tvalid.
REQ-015 SHALL have two states: EMPTY (mif_tvalid=0) and FULL (mif_tvalid=1).
REQ-016 SHALL compute accept = ~invalidate & (EMPTY | mif_tready).
REQ-017 SHALL pick winner combinationally among the asserted sif_tvalid bits; sif_tready[i] = accept & (winner==i); at most one sif_tready is high per cycle.
REQ-018 SHALL, on a sif handshake, load mif_tdata/mif_tid from the winner and go to (or stay in) FULL.
REQ-019 SHALL, on a mif handshake with no sif handshake, go to EMPTY.
REQ-020 SHALL, on a simultaneous mif and sif handshake, stay FULL with the new beat; full throughput is 1 beat/cycle.
REQ-021 SHALL keep mif_tdata and mif_tid stable while FULL and mif_tready=0.
REQ-022 SHALL, when invalidate=1, go to EMPTY at the next edge, drop the held beat, and accept no input that cycle. invalidate has priority over every other event.
REQ-023 SHALL leave the arbitration pointer unchanged by invalidate and by cycles with no handshake.
REQ-024 SHALL require no combinational path from mif_tready to mif_tvalid or mif_tdata.

Reset
REQ-025 SHALL, while rst_n=0, force mif_tvalid=0, mif_tdata=0, mif_tid=0, state EMPTY, pointer=0, and all sif_tready=0.
REQ-026 SHALL discard any held beat when reset asserts mid-transfer, without emitting it after release.

Configuration
REQ-027 SHALL support macro OFFNARISCV_AXIS_ARBITER_RR_EN.
REQ-028 SHALL, when the macro is defined, arbitrate round-robin: search starts at pointer, and pointer = winner+1 (mod NUM_SIF) after each sif handshake.
REQ-029 SHALL, when the macro is undefined, arbitrate by fixed priority (lowest index wins) and omit the pointer register.

Structure
REQ-030 SHALL place the grant index typedef and the state enum (EMPTY/FULL) in the shared package offnariscv_pkg.
REQ-031 SHALL implement winner selection in one sub-module, axis_arb_pick (inputs: request vector, pointer; outputs: winner index, any-request flag).
REQ-032 SHALL drive mif through an axis_if instance inside any wrapper used for test.

Verification
REQ-033 SHALL cover: NUM_SIF=2, RR; both valid, data 0xA0/0xB0, mif_tready=1 -> mif carries A0(id0), B0(id1), A0, B0 on consecutive cycles.
REQ-034 SHALL cover: fixed priority; both valid continuously -> only id0 beats appear, and sif_tready[1] stays 0.
REQ-035 SHALL cover: FULL with 0x11, mif_tready=0 for 3 cycles -> mif_tdata stays 0x11, and all sif_tready stay 0.
REQ-036 SHALL cover: FULL with 0x22, invalidate=1 with sif0 valid -> next cycle mif_tvalid=0, 0x22 is never handshaken, and sif0 is not accepted that cycle.
REQ-037 SHALL cover: rst_n deasserted mid-transfer while FULL -> mif_tvalid=0 immediately, and pointer=0 after release.
REQ-038 SHALL cover: only sif1 valid, mif_tready=1 -> beat 0x33 appears with mif_tid=1 one cycle after the handshake.

Source files
------------

// File: rtl/offnariscv_pkg.sv
// offnariscv_pkg -- shared types for the AXI-Stream arbiter slice.
//
// Contents:
//   SIF_ID_MAX_W : width that holds any legal grant index (up to 8 requesters)
//   sif_id_t     : grant index type used between the picker and the arbiter
//   arb_state_e  : output-register occupancy (EMPTY: mif_tvalid=0, FULL: mif_tvalid=1)
package offnariscv_pkg;

  localparam int SIF_ID_MAX_W = 3;

  typedef logic [SIF_ID_MAX_W-1:0] sif_id_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/axis_arb_pick.sv
// axis_arb_pick -- combinational winner selection.
//
// Scans the request vector starting at index ptr and wrapping modulo
// NUM_SIF; the first asserted request wins. With ptr tied to zero this
// is plain lowest-index-first priority.
//
// Ports:
//   req     in  NUM_SIF   request vector (sif_tvalid)
//   ptr     in  ID_WIDTH  index at which the search starts
//   winner  out sif_id_t  index of the winning requester (0 when none)
//   any_req out 1         at least one request is asserted
module axis_arb_pick
  import offnariscv_pkg::*;
#(
  parameter int NUM_SIF  = 2,
  parameter int ID_WIDTH = 1
) (
  input  logic [NUM_SIF-1:0]  req,
  input  logic [ID_WIDTH-1:0] ptr,
  output sif_id_t             winner,
  output logic                any_req
);

  // One extra bit so ptr + offset never overflows before the wrap.
  localparam logic [ID_WIDTH:0] NUM_L = (ID_WIDTH+1)'(NUM_SIF);

  logic [ID_WIDTH:0] idx;
  logic              found;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < NUM_SIF; k++) begin
      idx = {1'b0, ptr} + (ID_WIDTH+1)'(k);
      if (idx >= NUM_L) begin
        idx = idx - NUM_L;
      end
      if (!found && req[idx[ID_WIDTH-1:0]]) begin
        found  = 1'b1;
        winner = sif_id_t'(idx[ID_WIDTH-1:0]);
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/axis_arbiter.sv
// axis_arbiter -- N-to-1 AXI-Stream arbiter with a registered output stage.
//
// Build option:
//   OFFNARISCV_AXIS_ARBITER_RR_EN  defined   -> round-robin arbitration
//                                  undefined -> fixed priority, lowest index wins
//
// Ports:
//   clk, rst_n       clock (rising edge) and asynchronous active-low reset
//   sif_tvalid/tdata per-requester stream inputs (NUM_SIF lanes)
//   sif_tready       per-requester ready, at most one high per cycle
//   mif_tvalid/tdata registered shared output stream
//   mif_tid          index of the requester whose beat is on mif
//   mif_tready       downstream ready
//   invalidate       drops the held output beat; blocks input that cycle
module axis_arbiter
  import offnariscv_pkg::*;
#(
  parameter  int NUM_SIF     = 2,
  parameter  int TDATA_WIDTH = 32,
  localparam int ID_WIDTH    = $clog2(NUM_SIF)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_SIF-1:0]                  sif_tvalid,
  input  logic [NUM_SIF-1:0][TDATA_WIDTH-1:0] sif_tdata,
  output logic [NUM_SIF-1:0]                  sif_tready,
  output logic                                mif_tvalid,
  output logic [TDATA_WIDTH-1:0]              mif_tdata,
  output logic [ID_WIDTH-1:0]                 mif_tid,
  input  logic                                mif_tready,
  input  logic                                invalidate
);

  arb_state_e             state_q, state_d;
  logic [TDATA_WIDTH-1:0] data_q, data_d;
  logic [ID_WIDTH-1:0]    tid_q, tid_d;
  logic [ID_WIDTH-1:0]    ptr_sel;
  sif_id_t                winner;
  logic                   any_req;
  logic                   accept;
  logic                   sif_hs;
  logic                   mif_hs;

  // rst_n gates accept so no requester sees ready while reset is held.
  assign accept = rst_n & ~invalidate & ((state_q == EMPTY) | mif_tready);
  assign sif_hs = accept & any_req;
  assign mif_hs = (state_q == FULL) & mif_tready;

  axis_arb_pick #(
    .NUM_SIF  (NUM_SIF),
    .ID_WIDTH (ID_WIDTH)
  ) u_pick (
    .req     (sif_tvalid),
    .ptr     (ptr_sel),
    .winner  (winner),
    .any_req (any_req)
  );

  // With no request there is no winner, so no lane is offered ready.
  generate
    for (genvar gi = 0; gi < NUM_SIF; gi++) begin : g_ready
      assign sif_tready[gi] = accept & any_req & (winner == sif_id_t'(gi));
    end
  endgenerate

`ifdef OFFNARISCV_AXIS_ARBITER_RR_EN
  logic [ID_WIDTH-1:0] ptr_q, ptr_d;
  logic [ID_WIDTH-1:0] ptr_next;

  assign ptr_sel  = ptr_q;
  assign ptr_next = (winner[ID_WIDTH-1:0] == ID_WIDTH'(NUM_SIF - 1))
                  ? '0 : winner[ID_WIDTH-1:0] + ID_WIDTH'(1);

  // Pointer only advances on an accepted input beat.
  always_comb begin
    ptr_d = ptr_q;
    if (sif_hs) begin
      ptr_d = ptr_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  assign ptr_sel = '0;
`endif

  // invalidate wins over everything; a new input beat overrides a drain,
  // which gives back-to-back throughput.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    tid_d   = tid_q;
    if (invalidate) begin
      state_d = EMPTY;
    end else if (sif_hs) begin
      state_d = FULL;
      data_d  = sif_tdata[winner[ID_WIDTH-1:0]];
      tid_d   = winner[ID_WIDTH-1:0];
    end else if (mif_hs) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
      tid_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      tid_q   <= tid_d;
    end
  end

  assign mif_tvalid = (state_q == FULL);
  assign mif_tdata  = data_q;
  assign mif_tid    = tid_q;

endmodule
